// File: rtl/sipo_deserializer.sv
// sipo_deserializer: parametrised serial-in/parallel-out deserializer.
// Collects WIDTH bits qualified by bit_valid into a registered word with a
// valid/ready handshake, a sticky overflow flag and frame resync.
// Optional even-parity checking is enabled by defining SIPO_PARITY_CHECK_EN;
// in that build each frame carries one extra trailing parity bit.

module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_base;
  logic [WIDTH-1:0] shreg_shift;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             last_bit;
  logic             load_word;
  logic             drop_word;
  logic             consume;

  // A sync edge restarts the frame, so the bit arriving with it can never
  // complete a word; it shifts into an empty register as bit 0.
  assign last_bit  = bit_valid && !sync && (cnt == CW'(FRAME - 1));
  assign consume   = word_valid && word_ready;
  assign load_word = last_bit && (!word_valid || word_ready);
  assign drop_word = last_bit && word_valid && !word_ready;

  // Shift path, counter and completed-word selection.
  always_comb begin
    shreg_base  = sync ? '0 : shreg;
    shreg_shift = MSB_FIRST ? {shreg_base[WIDTH-2:0], data_in}
                            : {data_in, shreg_base[WIDTH-1:1]};
    shreg_nxt   = shreg_base;
    cnt_nxt     = sync ? '0 : cnt;
`ifdef SIPO_PARITY_CHECK_EN
    // The trailing parity bit is checked, not stored.
    word_nxt    = shreg;
    if (bit_valid && !last_bit) begin
      shreg_nxt = shreg_shift;
    end
`else
    word_nxt    = shreg_shift;
    if (bit_valid) begin
      shreg_nxt = shreg_shift;
    end
`endif
    if (bit_valid) begin
      cnt_nxt = last_bit ? '0 : (cnt_nxt + 1'b1);
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output word register and handshake; a completion while the previous
  // word is still pending is dropped and flagged instead of overwriting it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= '0;
      word_valid <= 1'b0;
    end else if (load_word) begin
      data_out   <= word_nxt;
      word_valid <= 1'b1;
    end else if (consume) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky overflow, cleared only by reset or a frame resync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (sync) begin
      overflow <= 1'b0;
    end else if (drop_word) begin
      overflow <= 1'b1;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic parity_q;

  // Parity result travels with data_out and follows the same drop rule.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (load_word) begin
      parity_q <= (^shreg) ^ data_in;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed, table-driven bench for sipo_deserializer.
// Two instances share the stimulus: one MSB-first, one LSB-first.
// Works in both the default build and with SIPO_PARITY_CHECK_EN defined.

module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic       bit_valid;
  logic       sync;
  logic       word_ready;
  logic [7:0] data_msb;
  logic [7:0] data_lsb;
  logic       wv_msb;
  logic       wv_lsb;
  logic       ovf_msb;
  logic       ovf_lsb;
  logic       perr_msb;
  logic       perr_lsb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] word;     // transmitted first bit = word[7]
    int         gap;      // idle cycles between bits
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[7];

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .bit_valid(bit_valid),
    .sync(sync), .data_out(data_msb), .word_valid(wv_msb),
    .word_ready(word_ready), .overflow(ovf_msb), .parity_err(perr_msb)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .bit_valid(bit_valid),
    .sync(sync), .data_out(data_lsb), .word_valid(wv_lsb),
    .word_ready(word_ready), .overflow(ovf_lsb), .parity_err(perr_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit with_sync, input bit rdy);
    data_in   = b;
    bit_valid = 1'b1;
    sync      = with_sync;
    if (rdy) word_ready = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    sync      = 1'b0;
  endtask

  // Sends one frame; rdy_last raises word_ready together with the final bit.
  task automatic send_word(input logic [7:0] w, input int gap, input bit par_flip,
                           input bit rdy_last, input bit sync_first);
    for (int i = 7; i >= 0; i--) begin
      if (i != 7) idle(gap);
`ifdef SIPO_PARITY_CHECK_EN
      send_bit(w[i], (i == 7) && sync_first, 1'b0);
`else
      send_bit(w[i], (i == 7) && sync_first, rdy_last && (i == 0));
`endif
    end
`ifdef SIPO_PARITY_CHECK_EN
    idle(gap);
    send_bit((^w) ^ par_flip, 1'b0, rdy_last);
`endif
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'hC0, 0, 8'hC0, 8'h03};
    vecs[2] = '{8'hA5, 1, 8'hA5, 8'hA5};
    vecs[3] = '{8'hA5, 2, 8'hA5, 8'hA5};
    vecs[4] = '{8'h12, 3, 8'h12, 8'h48};
    vecs[5] = '{8'h3C, 1, 8'h3C, 8'h3C};
    vecs[6] = '{8'hF0, 0, 8'hF0, 8'h0F};

    // Reset with random inputs
    rst = 1'b0;
    data_in = 1'b0; bit_valid = 1'b0; sync = 1'b0; word_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_in    = 1'($urandom_range(0, 1));
      bit_valid  = 1'($urandom_range(0, 1));
      sync       = 1'($urandom_range(0, 1));
      word_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("rst_data_msb", 32'(data_msb), 0);
    check("rst_data_lsb", 32'(data_lsb), 0);
    check("rst_wv", 32'({wv_msb, wv_lsb}), 0);
    check("rst_ovf", 32'({ovf_msb, ovf_lsb}), 0);
    check("rst_perr", 32'({perr_msb, perr_lsb}), 0);
    rst = 1'b1; data_in = 1'b0; bit_valid = 1'b0; sync = 1'b0; word_ready = 1'b1;
    idle(2);
    check("idle_wv", 32'({wv_msb, wv_lsb}), 0);

    // Table: word assembly, bit order, bit_valid gaps, one-cycle valid
    for (int v = 0; v < 7; v++) begin
      word_ready = 1'b1;
      send_word(vecs[v].word, vecs[v].gap, 1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_data_msb", v), 32'(data_msb), 32'(vecs[v].exp_msb));
      check($sformatf("v%0d_data_lsb", v), 32'(data_lsb), 32'(vecs[v].exp_lsb));
      check($sformatf("v%0d_wv", v), 32'({wv_msb, wv_lsb}), 32'h3);
      check($sformatf("v%0d_perr", v), 32'({perr_msb, perr_lsb}), 0);
      idle(1);
      check($sformatf("v%0d_wv_fall", v), 32'({wv_msb, wv_lsb}), 0);
      check($sformatf("v%0d_data_hold", v), 32'(data_msb), 32'(vecs[v].exp_msb));
    end

    // Overflow: second word dropped while first is pending
    word_ready = 1'b0;
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_first_wv", 32'(wv_msb), 1);
    check("ovf_first_flag", 32'(ovf_msb), 0);
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_data_msb", 32'(data_msb), 32'hA5);
    check("ovf_data_lsb", 32'(data_lsb), 32'hA5);
    check("ovf_wv", 32'({wv_msb, wv_lsb}), 32'h3);
    check("ovf_flag", 32'({ovf_msb, ovf_lsb}), 32'h3);
    word_ready = 1'b1;
    idle(1);
    check("ovf_consume_wv", 32'({wv_msb, wv_lsb}), 0);
    check("ovf_sticky", 32'({ovf_msb, ovf_lsb}), 32'h3);
    idle(3);
    check("ovf_sticky_later", 32'(ovf_msb), 1);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("ovf_sync_clear", 32'({ovf_msb, ovf_lsb}), 0);
    check("ovf_sync_data", 32'(data_msb), 32'hA5);
    check("ovf_sync_wv", 32'(wv_msb), 0);

    // Resync discards a partial frame
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    check("partial_wv", 32'(wv_msb), 0);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    send_word(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    check("resync_ff_msb", 32'(data_msb), 32'hFF);
    check("resync_ff_lsb", 32'(data_lsb), 32'hFF);
    check("resync_ff_wv", 32'(wv_msb), 1);
    idle(1);

    // sync together with bit_valid: that bit is bit 0 of the new frame
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_word(8'h96, 0, 1'b0, 1'b0, 1'b1);
    check("syncbit_msb", 32'(data_msb), 32'h96);
    check("syncbit_lsb", 32'(data_lsb), 32'h69);
    check("syncbit_wv", 32'({wv_msb, wv_lsb}), 32'h3);
    idle(1);

    // Completion on the same edge as consumption
    word_ready = 1'b0;
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    check("cc_first_data", 32'(data_msb), 32'h3C);
    send_word(8'hC0, 0, 1'b0, 1'b1, 1'b0);
    check("cc_data_msb", 32'(data_msb), 32'hC0);
    check("cc_data_lsb", 32'(data_lsb), 32'h03);
    check("cc_wv", 32'({wv_msb, wv_lsb}), 32'h3);
    check("cc_ovf", 32'({ovf_msb, ovf_lsb}), 0);
    idle(1);
    check("cc_wv_fall", 32'(wv_msb), 0);

`ifdef SIPO_PARITY_CHECK_EN
    // Even parity: A5 has four ones, so parity bit 0 is correct
    word_ready = 1'b1;
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    check("par_ok_data", 32'(data_msb), 32'hA5);
    check("par_ok_err", 32'({perr_msb, perr_lsb}), 0);
    idle(1);
    send_word(8'hA5, 1, 1'b1, 1'b0, 1'b0);
    check("par_bad_data", 32'(data_msb), 32'hA5);
    check("par_bad_err", 32'({perr_msb, perr_lsb}), 32'h3);
    idle(1);
    check("par_err_hold", 32'(perr_msb), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer, successor to the fixed 8-bit SIPO shift register. Assembles WIDTH serial bits, qualified by a bit-enable, into a word. Supports selectable bit order, frame resync, and a registered output word with valid/ready handshake and overflow flag. Sits between a serial receive front-end and word-oriented consumer logic.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first received bit lands in data_out[0]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
data_in  input  1  serial data bit
bit_valid  input  1  data_in sampled on this edge when 1
sync  input  1  frame restart: discard partial word
data_out  output  WIDTH  assembled word, registered
word_valid  output  1  data_out holds an unconsumed word
word_ready  input  1  consumer accepts word when word_valid & word_ready
overflow  output  1  sticky: a completed word was dropped
parity_err  output  1  parity result for data_out (see Optional Feature)

Behaviour:
- One clock (clk); reset synchronous, active-low on rst: sampled on rising clk edge when rst==0.
- Reset values: shift register 0, bit counter 0, data_out 0, word_valid 0, overflow 0, parity_err 0.
- Shift: on bit_valid=1, MSB_FIRST=1 -> shreg <= {shreg[WIDTH-2:0], data_in}; MSB_FIRST=0 -> shreg <= {data_in, shreg[WIDTH-1:1]}. bit_valid=0 -> hold.
- Bit counter 0..FRAME-1 (FRAME=WIDTH, or WIDTH+1 with parity), increments on bit_valid, wraps to 0 after last bit of frame.
- Word completion: edge where bit_valid=1 and counter==FRAME-1. On that edge the complete word (including the current bit) loads into data_out and word_valid sets. word_valid is visible the cycle after the last bit is sampled, so latency is 1 clk.
- Handshake: word_valid & word_ready on an edge consumes the word; word_valid clears the next cycle unless a new word completes on the same edge.
- Simultaneous complete + consume: new word loads, word_valid stays 1, no overflow.
- Complete while word_valid=1 & word_ready=0: new word dropped. data_out unchanged. overflow <= 1. Counter still wraps to 0.
- overflow clears only on reset or sync.
- sync=1: counter <= 0, shreg <= 0, overflow <= 0. data_out and word_valid are untouched.
- sync=1 with bit_valid=1 on the same edge: that bit becomes bit 0 of the new frame, and the counter goes to 1.
- data_out, word_valid and parity_err change only on completion, consumption or reset.

Optional Feature:
Macro SIPO_PARITY_CHECK_EN.
- Defined:
  - FRAME=WIDTH+1; the final serial bit is an even-parity bit and is not shifted into the data.
  - On completion, parity_err <= XOR(word bits, parity bit). It is loaded together with data_out and obeys the same drop rule.
- Undefined:
  - FRAME=WIDTH.
  - parity_err is tied to 0; the port remains present so the interface is stable.

Test Plan:
1. Hold rst=0 for 2 clks with random inputs -> data_out=0, word_valid=0, overflow=0, parity_err=0.
2. WIDTH=8, MSB_FIRST=1, word_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> data_out=8'hA5, word_valid=1 for exactly 1 cycle, starting the cycle after the 8th bit. Repeat with bit_valid gaps of 1-3 cycles -> same result.
3. MSB_FIRST=0, same bit sequence -> data_out=8'hA5 reversed = 8'hA5 (palindrome check fails), so use bits 1,1,0,0,0,0,0,0 -> data_out=8'h03.
4. word_ready=0, send 0xA5 then 0x3C -> data_out stays 0xA5, word_valid=1, overflow=1. Raise word_ready -> word_valid falls next cycle, overflow stays 1 until sync.
5. Send 3 bits, pulse sync, then 8 bits of 0xFF -> data_out=8'hFF with no corruption. sync+bit_valid on the same edge counts as bit 0.
6. SIPO_PARITY_CHECK_EN defined: 0xA5 followed by parity 0 -> parity_err=0; 0xA5 followed by parity 1 -> parity_err=1. Complete on the same edge as consume -> word_valid stays high, overflow=0.
